// File: rtl/da3_feed_pkg.sv
// Shared constants, FSM state type and saturation helper for the
// offset-binary distributed-arithmetic feeder (da3_feed).
//   XW   : sample width
//   CW   : coefficient / LUT entry width
//   NTAP : tap count (fixed at 4)
//   NLUT : LUT depth, 2^(NTAP-1)
package da_pkg;

   localparam int XW   = 8;
   localparam int CW   = 10;
   localparam int NTAP = 4;
   localparam int NLUT = 8;
   localparam int SW   = 12;   // width of the unshifted entry sum

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      SWAP  = 2'd2
   } state_t;

   // Clamp bounds, at CW bits and at the CW+1 width of the halved sum
   localparam logic signed [CW:0]   SAT_MAX_W = 11'sd511;
   localparam logic signed [CW:0]   SAT_MIN_W = -11'sd512;
   localparam logic signed [CW-1:0] SAT_MAX   = SAT_MAX_W[CW-1:0];
   localparam logic signed [CW-1:0] SAT_MIN   = SAT_MIN_W[CW-1:0];

   // Clamp a CW+1 bit signed value into the CW-bit entry range
   function automatic logic signed [CW-1:0] sat_cw(input logic signed [CW:0] v);
      logic signed [CW-1:0] r;
      if (v > SAT_MAX_W) begin
         r = SAT_MAX;
      end else if (v < SAT_MIN_W) begin
         r = SAT_MIN;
      end else begin
         r = v[CW-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/da3_feed_if.sv
// Bus bundle between the feeder and its environment.
//   sample path : sample_valid, sample -> x1..x4, x_valid
//   coef path   : coef_valid, coef_idx, coef_data, coef_commit -> coef_ready
//   LUT path    : lut_busy, lut_swap, w1..w8
// master = environment side, slave = da3_feed.
interface da3_feed_if;
   import da_pkg::*;

   logic                 sample_valid;
   logic signed [XW-1:0] sample;
   logic signed [XW-1:0] x1, x2, x3, x4;
   logic                 x_valid;

   logic                 coef_valid;
   logic [1:0]           coef_idx;
   logic signed [CW-1:0] coef_data;
   logic                 coef_ready;
   logic                 coef_commit;

   logic                 lut_busy;
   logic                 lut_swap;
   logic signed [CW-1:0] w1, w2, w3, w4, w5, w6, w7, w8;

   modport master (
      output sample_valid, sample, coef_valid, coef_idx, coef_data, coef_commit,
      input  x1, x2, x3, x4, x_valid, coef_ready, lut_busy, lut_swap,
             w1, w2, w3, w4, w5, w6, w7, w8
   );

   modport slave (
      input  sample_valid, sample, coef_valid, coef_idx, coef_data, coef_commit,
      output x1, x2, x3, x4, x_valid, coef_ready, lut_busy, lut_swap,
             w1, w2, w3, w4, w5, w6, w7, w8
   );

endinterface

// File: rtl/da3_feed_obc.sv
// obc_entry_calc: combinational OBC LUT entry generator.
//   h1..h4 : coefficients (CW-bit signed)
//   idx    : entry index {a4,a3,a2}, a2 = LSB; a bit of 1 negates that tap
//   entry  : saturate((h1 +/- h2 +/- h3 +/- h4) >>> 1)
module obc_entry_calc
   import da_pkg::*;
(
   input  logic signed [CW-1:0] h1,
   input  logic signed [CW-1:0] h2,
   input  logic signed [CW-1:0] h3,
   input  logic signed [CW-1:0] h4,
   input  logic [2:0]           idx,
   output logic signed [CW-1:0] entry
);

   logic signed [SW-1:0] t2_s, t3_s, t4_s, sum_s;

   // Sign-extend, apply the per-tap sign, sum, halve with floor, clamp
   always_comb begin
      t2_s = SW'(h2);
      t3_s = SW'(h3);
      t4_s = SW'(h4);
      if (idx[0]) begin
         t2_s = -t2_s;
      end else begin
         t2_s = t2_s;
      end
      if (idx[1]) begin
         t3_s = -t3_s;
      end else begin
         t3_s = t3_s;
      end
      if (idx[2]) begin
         t4_s = -t4_s;
      end else begin
         t4_s = t4_s;
      end
      sum_s = SW'(h1) + t2_s + t3_s + t4_s;
      // dropping the LSB of a two's complement value is an arithmetic
      // shift right by one with floor rounding
      entry = sat_cw(sum_s[SW-1:1]);
   end

endmodule

// File: rtl/da3_feed.sv
// da3_feed: front end of the 4-tap OBC distributed-arithmetic kernel.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : da3_feed_if.slave -- sample delay line (x1..x4, x_valid),
//                coefficient writes/commit, and the double-buffered LUT
//                (w1..w8) with lut_busy / lut_swap status.
// The delay line runs freely; coefficient handling is a small
// IDLE -> BUILD (8 cycles, one entry each) -> SWAP FSM.
module da3_feed
   import da_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   da3_feed_if.slave   bus
);

   logic signed [XW-1:0] tap_r [NTAP];
   logic                 x_valid_r;

   logic signed [CW-1:0] coef_r       [NTAP];
   logic signed [CW-1:0] shadow_lut_r [NLUT];
   logic signed [CW-1:0] active_lut_r [NLUT];
   state_t               state_r;
   logic [2:0]           cnt_r;
   logic                 coef_ready_r;
   logic                 lut_busy_r;
   logic                 lut_swap_r;
   logic signed [CW-1:0] entry_s;

   obc_entry_calc u_entry (
      .h1    (coef_r[0]),
      .h2    (coef_r[1]),
      .h3    (coef_r[2]),
      .h4    (coef_r[3]),
      .idx   (cnt_r),
      .entry (entry_s)
   );

   // Sample delay line: shifts on every valid sample, never stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAP; i++) tap_r[i] <= '0;
         x_valid_r <= 1'b0;
      end else begin
         x_valid_r <= bus.sample_valid;
         if (bus.sample_valid) begin
            tap_r[3] <= tap_r[2];
            tap_r[2] <= tap_r[1];
            tap_r[1] <= tap_r[0];
            tap_r[0] <= bus.sample;
         end
      end
   end

   // Coefficient capture, LUT build and deferred shadow-to-active swap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAP; i++) coef_r[i] <= '0;
         for (int i = 0; i < NLUT; i++) begin
            shadow_lut_r[i] <= '0;
            active_lut_r[i] <= '0;
         end
         state_r      <= IDLE;
         cnt_r        <= 3'd0;
         coef_ready_r <= 1'b1;
         lut_busy_r   <= 1'b0;
         lut_swap_r   <= 1'b0;
      end else begin
         lut_swap_r <= 1'b0;
         case (state_r)
            IDLE: begin
               // a write landing with the commit is in coef_r before BUILD reads it
               if (bus.coef_valid && coef_ready_r) begin
                  coef_r[bus.coef_idx] <= bus.coef_data;
               end
               if (bus.coef_commit) begin
                  state_r      <= BUILD;
                  cnt_r        <= 3'd0;
                  coef_ready_r <= 1'b0;
                  lut_busy_r   <= 1'b1;
               end
            end
            BUILD: begin
               shadow_lut_r[cnt_r] <= entry_s;
               cnt_r               <= cnt_r + 3'd1;
               if (cnt_r == 3'd7) begin
                  state_r <= SWAP;
               end
            end
            SWAP: begin
               // only swap on an idle sample cycle so the kernel never
               // mixes two tables within one sample
               if (!bus.sample_valid) begin
                  for (int i = 0; i < NLUT; i++) active_lut_r[i] <= shadow_lut_r[i];
                  lut_swap_r   <= 1'b1;
                  state_r      <= IDLE;
                  coef_ready_r <= 1'b1;
                  lut_busy_r   <= 1'b0;
               end
            end
            default: begin
               state_r      <= IDLE;
               cnt_r        <= 3'd0;
               coef_ready_r <= 1'b1;
               lut_busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.x1         = tap_r[0];
   assign bus.x2         = tap_r[1];
   assign bus.x3         = tap_r[2];
   assign bus.x4         = tap_r[3];
   assign bus.x_valid    = x_valid_r;
   assign bus.coef_ready = coef_ready_r;
   assign bus.lut_busy   = lut_busy_r;
   assign bus.lut_swap   = lut_swap_r;
   assign bus.w1         = active_lut_r[0];
   assign bus.w2         = active_lut_r[1];
   assign bus.w3         = active_lut_r[2];
   assign bus.w4         = active_lut_r[3];
   assign bus.w5         = active_lut_r[4];
   assign bus.w6         = active_lut_r[5];
   assign bus.w7         = active_lut_r[6];
   assign bus.w8         = active_lut_r[7];

endmodule
